// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the 1RW+1R write-masked SRAM model.
// The merge helper works on a wide fixed word so every instance width can share it.
package sram_model_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int RW_OLD_DATA = 0;
    localparam int RW_NEW_DATA = 1;

    localparam int MERGE_MAX_W = 1024;
    typedef logic [MERGE_MAX_W-1:0] merge_word_t;

    // bit_mask is the per-segment write mask already expanded to one bit per data bit.
    function automatic merge_word_t merge_wmask(
        input merge_word_t old_word,
        input merge_word_t new_word,
        input merge_word_t bit_mask
    );
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/sram_1rw1r_wmask_model_if.sv
// Request/response bundle for the 1RW+1R SRAM model.
// master = requester (core pipeline), slave = memory model.
interface sram_1rw1r_wmask_model_if #(
    parameter int DATA_WIDTH = 150,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 3
);

    logic                  init_done;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;

    modport master (
        input  init_done, dout0, dout0_valid, dout1, dout1_valid,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output init_done, dout0, dout0_valid, dout1, dout1_valid,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

endinterface

// File: rtl/sram_1rw1r_wmask_model_rd_pipe.sv
// Read-return pipeline for one SRAM port: one or two register stages carrying valid and data.
// Data registers only load on a valid beat, so dout holds its last result between reads.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 150,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_data <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk0) begin
                if (rst0) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout       = s2_data;
            assign dout_valid = s2_valid;
        end else begin : g_no_out_reg
            assign dout       = s1_data;
            assign dout_valid = s1_valid;
        end
    endgenerate

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW+1R SRAM with per-segment write mask, post-reset clear sweep,
// optional output register and selectable same-address read/write collision policy.
module sram_1rw1r_wmask_model
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH   = 150,
    parameter int ADDR_WIDTH   = 9,
    parameter int WRITE_SIZE   = 50,
    parameter int OUT_REG      = 0,
    parameter int RW_COLLISION = RW_OLD_DATA,
    parameter int INIT_CLEAR   = 1
) (
    input logic                    clk0,
    input logic                    rst0,
    sram_1rw1r_wmask_model_if.slave bus
);

    // state | meaning
    // CLEAR | after reset; zeroes mem[ptr] each cycle (INIT_CLEAR=1), requests ignored
    // READY | init_done=1; both ports accept requests every cycle

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

    generate
        if (DATA_WIDTH % WRITE_SIZE != 0) begin : g_bad_write_size
            $fatal(1, "DATA_WIDTH (%0d) is not a multiple of WRITE_SIZE (%0d)", DATA_WIDTH, WRITE_SIZE);
        end
        if (DATA_WIDTH >= MERGE_MAX_W) begin : g_bad_data_width
            $fatal(1, "DATA_WIDTH (%0d) must be below MERGE_MAX_W (%0d)", DATA_WIDTH, MERGE_MAX_W);
        end
    endgenerate

    sram_state_e           state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  init_done;
    logic                  clear_en;
    logic                  wr_en0;
    logic                  rd_en0;
    logic                  rd_en1;
    logic                  collide;
    logic [DATA_WIDTH-1:0] bit_mask0;
    logic [DATA_WIDTH-1:0] rd_word0;
    logic [DATA_WIDTH-1:0] rd_word1;
    logic [DATA_WIDTH-1:0] merged0;
    logic [DATA_WIDTH-1:0] port1_word;
    merge_word_t           merged_full;
    logic                  unused_merge_hi;

    assign init_done     = (state_q == READY);
    assign bus.init_done = init_done;

    assign clear_en = (INIT_CLEAR != 0) && (state_q == CLEAR) && !rst0;
    assign wr_en0   = init_done && !bus.csb0 && !bus.web0;
    assign rd_en0   = init_done && !bus.csb0 &&  bus.web0;
    assign rd_en1   = init_done && !bus.csb1;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else if (state_q == CLEAR) begin
            // Stop on the last address instead of letting ptr wrap into a second pass.
            if ((INIT_CLEAR == 0) || (&ptr_q)) begin
                state_q <= READY;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        bit_mask0 = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            bit_mask0[i*WRITE_SIZE +: WRITE_SIZE] = {WRITE_SIZE{bus.wmask0[i]}};
        end
    end

    assign rd_word0 = mem[bus.addr0];
    assign rd_word1 = mem[bus.addr1];

    assign merged_full     = merge_wmask(merge_word_t'(rd_word0), merge_word_t'(bus.din0),
                                         merge_word_t'(bit_mask0));
    assign merged0         = merged_full[DATA_WIDTH-1:0];
    assign unused_merge_hi = ^merged_full[MERGE_MAX_W-1:DATA_WIDTH];

    // The array updates non-blocking, so port1 sees the old word unless we forward the merge.
    assign collide    = wr_en0 && rd_en1 && (bus.addr0 == bus.addr1);
    assign port1_word = (RW_COLLISION == RW_NEW_DATA && collide) ? merged0 : rd_word1;

    always_ff @(posedge clk0) begin
        if (clear_en) begin
            mem[ptr_q] <= '0;
        end else if (wr_en0 && !rst0) begin
            mem[bus.addr0] <= merged0;
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe0 (
        .clk0       (clk0),
        .rst0       (rst0),
        .rd_en      (rd_en0),
        .rd_data    (rd_word0),
        .dout       (bus.dout0),
        .dout_valid (bus.dout0_valid)
    );

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe1 (
        .clk0       (clk0),
        .rst0       (rst0),
        .rd_en      (rd_en1),
        .rd_data    (port1_word),
        .dout       (bus.dout1),
        .dout_valid (bus.dout1_valid)
    );

`ifdef VERBOSE
    always @(posedge clk0) begin
        if (!rst0 && wr_en0)
            $display("%m: port0 write addr=%0d mask=%b data=%h", bus.addr0, bus.wmask0, bus.din0);
        if (!rst0 && rd_en0)
            $display("%m: port0 read addr=%0d", bus.addr0);
        if (!rst0 && rd_en1)
            $display("%m: port1 read addr=%0d", bus.addr1);
    end
`endif

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Directed bench for sram_1rw1r_wmask_model: three instances cover the default build,
// OUT_REG=1 with new-data collision, and INIT_CLEAR=0.
module tb_sram_1rw1r_wmask_model;

    localparam int DW = 150;
    localparam int AW = 9;
    localparam int NW = 3;

    logic clk0;
    logic rst0;
    int   checks;
    int   errors;

    logic [DW-1:0] ones;
    logic [DW-1:0] q_word;

    sram_1rw1r_wmask_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) ifa ();
    sram_1rw1r_wmask_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) ifb ();
    sram_1rw1r_wmask_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) ifc ();

    sram_1rw1r_wmask_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(50),
        .OUT_REG(0), .RW_COLLISION(0), .INIT_CLEAR(1)
    ) u_a (.clk0(clk0), .rst0(rst0), .bus(ifa));

    sram_1rw1r_wmask_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(50),
        .OUT_REG(1), .RW_COLLISION(1), .INIT_CLEAR(1)
    ) u_b (.clk0(clk0), .rst0(rst0), .bus(ifb));

    sram_1rw1r_wmask_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(50),
        .OUT_REG(0), .RW_COLLISION(0), .INIT_CLEAR(0)
    ) u_c (.clk0(clk0), .rst0(rst0), .bus(ifc));

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle_all();
        ifa.csb0 = 1'b1; ifa.web0 = 1'b1; ifa.wmask0 = '0; ifa.addr0 = '0; ifa.din0 = '0;
        ifa.csb1 = 1'b1; ifa.addr1 = '0;
        ifb.csb0 = 1'b1; ifb.web0 = 1'b1; ifb.wmask0 = '0; ifb.addr0 = '0; ifb.din0 = '0;
        ifb.csb1 = 1'b1; ifb.addr1 = '0;
        ifc.csb0 = 1'b1; ifc.web0 = 1'b1; ifc.wmask0 = '0; ifc.addr0 = '0; ifc.din0 = '0;
        ifc.csb1 = 1'b1; ifc.addr1 = '0;
    endtask

    function automatic logic [DW-1:0] word_b(input int k);
        logic [49:0] hi;
        logic [49:0] mid;
        logic [49:0] lo;
        hi  = 50'(k * 3 + 1);
        mid = 50'h3_0000_0000_0000 | 50'(k);
        lo  = 50'(k) << 20;
        return {hi, mid, lo};
    endfunction

    task automatic test_reset();
        int cnt;
        rst0 = 1'b1;
        idle_all();
        tick();
        tick();
        checks++;
        if (ifa.init_done !== 1'b0 || ifb.init_done !== 1'b0 || ifc.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_done a=%b b=%b c=%b expected 0", ifa.init_done, ifb.init_done, ifc.init_done);
        end
        checks++;
        if (ifa.dout0 !== '0 || ifa.dout0_valid !== 1'b0 || ifa.dout1 !== '0 || ifa.dout1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs dout0=%h v0=%b dout1=%h v1=%b expected zeros",
                     ifa.dout0, ifa.dout0_valid, ifa.dout1, ifa.dout1_valid);
        end
        rst0 = 1'b0;
        cnt = 0;
        while (ifa.init_done !== 1'b1 && cnt < 600) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                checks++;
                if (ifc.init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL noclear_ready got %b expected 1 one cycle after reset", ifc.init_done);
                end
            end
        end
        checks++;
        if (cnt != 512) begin
            errors++;
            $display("FAIL init_done_latency got %0d cycles expected 512", cnt);
        end
        checks++;
        if (ifb.init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_b got %b expected 1", ifb.init_done);
        end
    endtask

    task automatic test_clear_reads();
        ifa.csb0 = 1'b0; ifa.web0 = 1'b1; ifa.addr0 = 9'd0;
        ifa.csb1 = 1'b0; ifa.addr1 = 9'd255;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b1 || ifa.dout0 !== '0) begin
            errors++;
            $display("FAIL clear_read_0 v=%b data=%h expected v=1 data=0", ifa.dout0_valid, ifa.dout0);
        end
        checks++;
        if (ifa.dout1_valid !== 1'b1 || ifa.dout1 !== '0) begin
            errors++;
            $display("FAIL clear_read_255 v=%b data=%h expected v=1 data=0", ifa.dout1_valid, ifa.dout1);
        end
        ifa.csb0 = 1'b0; ifa.web0 = 1'b1; ifa.addr0 = 9'd511;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b1 || ifa.dout0 !== '0) begin
            errors++;
            $display("FAIL clear_read_511 v=%b data=%h expected v=1 data=0", ifa.dout0_valid, ifa.dout0);
        end
        tick();
        checks++;
        if (ifa.dout0_valid !== 1'b0 || ifa.dout1_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle v0=%b v1=%b expected 0 0", ifa.dout0_valid, ifa.dout1_valid);
        end
    endtask

    task automatic test_wmask();
        logic [DW-1:0] exp;
        logic [DW-1:0] pat;
        ifa.csb0 = 1'b0; ifa.web0 = 1'b0; ifa.wmask0 = 3'b101; ifa.addr0 = 9'd5; ifa.din0 = ones;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_no_valid got %b expected 0", ifa.dout0_valid);
        end
        exp = ones;
        exp[99:50] = '0;
        ifa.csb0 = 1'b0; ifa.web0 = 1'b1; ifa.addr0 = 9'd5;
        ifa.csb1 = 1'b0; ifa.addr1 = 9'd5;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b1 || ifa.dout0 !== exp) begin
            errors++;
            $display("FAIL wmask_101_p0 v=%b data=%h expected %h", ifa.dout0_valid, ifa.dout0, exp);
        end
        checks++;
        if (ifa.dout1_valid !== 1'b1 || ifa.dout1 !== exp) begin
            errors++;
            $display("FAIL wmask_101_p1 v=%b data=%h expected %h", ifa.dout1_valid, ifa.dout1, exp);
        end
        tick();
        checks++;
        if (ifa.dout0_valid !== 1'b0 || ifa.dout0 !== exp) begin
            errors++;
            $display("FAIL dout0_hold v=%b data=%h expected v=0 %h", ifa.dout0_valid, ifa.dout0, exp);
        end
        pat = {50'h1_2345_6789_ABCD, 50'h0_FEDC_BA98_7654, 50'h2_AAAA_5555_0F0F};
        ifa.csb0 = 1'b0; ifa.web0 = 1'b0; ifa.wmask0 = 3'b010; ifa.addr0 = 9'd5; ifa.din0 = pat;
        tick();
        ifa.wmask0 = 3'b000; ifa.din0 = '0;
        tick();
        idle_all();
        exp[99:50] = pat[99:50];
        ifa.csb0 = 1'b0; ifa.web0 = 1'b1; ifa.addr0 = 9'd5;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b1 || ifa.dout0 !== exp) begin
            errors++;
            $display("FAIL wmask_010_then_000 v=%b data=%h expected %h", ifa.dout0_valid, ifa.dout0, exp);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp;
        ifa.csb0 = 1'b0; ifa.web0 = 1'b0; ifa.wmask0 = 3'b111; ifa.addr0 = 9'd7; ifa.din0 = ones;
        ifa.csb1 = 1'b0; ifa.addr1 = 9'd7;
        tick();
        idle_all();
        checks++;
        if (ifa.dout1_valid !== 1'b1 || ifa.dout1 !== '0) begin
            errors++;
            $display("FAIL collision_old v=%b data=%h expected v=1 data=0", ifa.dout1_valid, ifa.dout1);
        end
        ifa.csb1 = 1'b0; ifa.addr1 = 9'd7;
        tick();
        idle_all();
        checks++;
        if (ifa.dout1_valid !== 1'b1 || ifa.dout1 !== ones) begin
            errors++;
            $display("FAIL write_visible_later v=%b data=%h expected %h", ifa.dout1_valid, ifa.dout1, ones);
        end
        exp = ones;
        exp[99:50] = '0;
        ifb.csb0 = 1'b0; ifb.web0 = 1'b0; ifb.wmask0 = 3'b101; ifb.addr0 = 9'd7; ifb.din0 = ones;
        ifb.csb1 = 1'b0; ifb.addr1 = 9'd7;
        tick();
        idle_all();
        checks++;
        if (ifb.dout1_valid !== 1'b0) begin
            errors++;
            $display("FAIL outreg_latency_early v=%b expected 0", ifb.dout1_valid);
        end
        tick();
        checks++;
        if (ifb.dout1_valid !== 1'b1 || ifb.dout1 !== exp) begin
            errors++;
            $display("FAIL collision_new v=%b data=%h expected %h", ifb.dout1_valid, ifb.dout1, exp);
        end
        tick();
        checks++;
        if (ifb.dout1_valid !== 1'b0 || ifb.dout1 !== exp) begin
            errors++;
            $display("FAIL outreg_hold v=%b data=%h expected v=0 %h", ifb.dout1_valid, ifb.dout1, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            ifb.csb0 = 1'b0; ifb.web0 = 1'b0; ifb.wmask0 = 3'b111;
            ifb.addr0 = 9'(k); ifb.din0 = word_b(k);
            tick();
        end
        idle_all();
        for (int step = 1; step <= 5; step++) begin
            if (step <= 3) begin
                ifb.csb1 = 1'b0; ifb.addr1 = 9'(step);
                ifb.csb0 = 1'b0; ifb.web0 = 1'b1; ifb.addr0 = 9'(4 - step);
            end else begin
                idle_all();
            end
            tick();
            checks++;
            if (step >= 2 && step <= 4) begin
                if (ifb.dout1_valid !== 1'b1 || ifb.dout1 !== word_b(step - 1) ||
                    ifb.dout0_valid !== 1'b1 || ifb.dout0 !== word_b(5 - step)) begin
                    errors++;
                    $display("FAIL b2b_step%0d v1=%b d1=%h v0=%b d0=%h expected d1=%h d0=%h", step,
                             ifb.dout1_valid, ifb.dout1, ifb.dout0_valid, ifb.dout0,
                             word_b(step - 1), word_b(5 - step));
                end
            end else begin
                if (ifb.dout1_valid !== 1'b0 || ifb.dout0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_step%0d v1=%b v0=%b expected 0 0", step, ifb.dout1_valid, ifb.dout0_valid);
                end
            end
        end
        idle_all();
    endtask

    task automatic test_no_clear_write();
        q_word = {50'h0_1357_9BDF_2468, 50'h3_C3C3_C3C3_C3C3, 50'h1_0000_FFFF_0001};
        ifc.csb0 = 1'b0; ifc.web0 = 1'b0; ifc.wmask0 = 3'b111; ifc.addr0 = 9'd20; ifc.din0 = q_word;
        tick();
        idle_all();
        ifc.csb1 = 1'b0; ifc.addr1 = 9'd20;
        tick();
        idle_all();
        checks++;
        if (ifc.dout1_valid !== 1'b1 || ifc.dout1 !== q_word) begin
            errors++;
            $display("FAIL noclear_write v=%b data=%h expected %h", ifc.dout1_valid, ifc.dout1, q_word);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        rst0 = 1'b1;
        tick();
        checks++;
        if (ifa.dout0 !== '0 || ifa.dout1 !== '0 || ifb.dout1 !== '0 || ifa.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_hold a.d0=%h a.d1=%h b.d1=%h done=%b expected zeros",
                     ifa.dout0, ifa.dout1, ifb.dout1, ifa.init_done);
        end
        rst0 = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        cnt = 0;
        while (ifa.init_done !== 1'b1 && cnt < 600) begin
            if (cnt == 299) begin
                ifa.csb0 = 1'b0; ifa.web0 = 1'b0; ifa.wmask0 = 3'b111; ifa.addr0 = 9'd10; ifa.din0 = ones;
                ifa.csb1 = 1'b0; ifa.addr1 = 9'd10;
            end
            tick();
            cnt++;
            if (cnt == 1) begin
                checks++;
                if (ifc.init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL noclear_ready_again got %b expected 1", ifc.init_done);
                end
            end
            if (cnt == 300) begin
                idle_all();
                checks++;
                if (ifa.dout0_valid !== 1'b0 || ifa.dout1_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gated_during_sweep v0=%b v1=%b expected 0 0", ifa.dout0_valid, ifa.dout1_valid);
                end
            end
        end
        checks++;
        if (cnt != 512) begin
            errors++;
            $display("FAIL restart_latency got %0d cycles expected 512", cnt);
        end
        ifa.csb0 = 1'b0; ifa.web0 = 1'b1; ifa.addr0 = 9'd5;
        ifa.csb1 = 1'b0; ifa.addr1 = 9'd10;
        ifc.csb1 = 1'b0; ifc.addr1 = 9'd20;
        tick();
        idle_all();
        checks++;
        if (ifa.dout0_valid !== 1'b1 || ifa.dout0 !== '0) begin
            errors++;
            $display("FAIL resweep_addr5 v=%b data=%h expected 0", ifa.dout0_valid, ifa.dout0);
        end
        checks++;
        if (ifa.dout1_valid !== 1'b1 || ifa.dout1 !== '0) begin
            errors++;
            $display("FAIL sweep_write_ignored v=%b data=%h expected 0", ifa.dout1_valid, ifa.dout1);
        end
        checks++;
        if (ifc.dout1_valid !== 1'b1 || ifc.dout1 !== q_word) begin
            errors++;
            $display("FAIL noclear_persist v=%b data=%h expected %h", ifc.dout1_valid, ifc.dout1, q_word);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ones   = '1;
        q_word = '0;
        rst0   = 1'b1;
        idle_all();
        test_reset();
        test_clear_reads();
        test_wmask();
        test_collision();
        test_back_to_back();
        test_no_clear_write();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
